river_reg_scoreboard: RTL and testbench

- Parametrised successor to the execute stage's single tag-counter register scoreboard.
- Per architectural register it holds:
  - the last issued write tag;
  - an outstanding-write counter.
- It supports several writeback ports and several read-check ports.
- Writers are the integer/FPU/memory pipes, which may complete out of order. The block issues tags, commits only the newest write per register (WAW safe), and reports RAW readiness to the issue logic.

---
 rtl/river_reg_scoreboard.sv | 116 +++++++++++
 tb/tb_river_reg_scoreboard.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/river_reg_scoreboard.sv
// Multi-port register scoreboard: issues per-register write tags, commits only the
// newest writeback per register and reports RAW readiness from outstanding counts.
module river_reg_scoreboard #(
  parameter int REGS_TOTAL = 64,
  parameter int TAG_WIDTH  = 3,
  parameter int WB_PORTS   = 2,
  parameter int RD_PORTS   = 3
) (
  input  logic                          i_clk,
  input  logic                          i_nrst,
  input  logic                          i_clear,
  input  logic                          i_issue_valid,
  input  logic [5:0]                    i_issue_waddr,
  output logic                          o_issue_ready,
  output logic [TAG_WIDTH-1:0]          o_issue_tag,
  input  logic [WB_PORTS-1:0]           i_wb_valid,
  input  logic [6*WB_PORTS-1:0]         i_wb_waddr,
  input  logic [TAG_WIDTH*WB_PORTS-1:0] i_wb_tag,
  output logic [WB_PORTS-1:0]           o_wb_commit,
  input  logic [6*RD_PORTS-1:0]         i_rd_addr,
  output logic [RD_PORTS-1:0]           o_rd_ready,
  output logic                          o_err
);

  localparam int AW = 6;
  localparam logic [TAG_WIDTH-1:0] MAXCNT = '1;

  logic [TAG_WIDTH-1:0] itag_q [REGS_TOTAL];
  logic [TAG_WIDTH-1:0] itag_d [REGS_TOTAL];
  logic [TAG_WIDTH-1:0] cnt_q  [REGS_TOTAL];
  logic [TAG_WIDTH-1:0] cnt_d  [REGS_TOTAL];
  logic                 err_q;
  logic                 err_d;
  logic                 issueAcc;
  int                   net;

  // x0 is never tracked, so issue to it is always ready with a zero tag.
  always_comb begin
    o_issue_ready = 1'b1;
    o_issue_tag   = '0;
    if (i_issue_waddr != '0) begin
      o_issue_ready = (cnt_q[i_issue_waddr] != MAXCNT);
      o_issue_tag   = itag_q[i_issue_waddr] + TAG_WIDTH'(1);
    end
    issueAcc = i_issue_valid && o_issue_ready && (i_issue_waddr != '0);
  end

  always_comb begin
    for (int p = 0; p < WB_PORTS; p++) begin
      o_wb_commit[p] = i_wb_valid[p]
                    && (i_wb_waddr[p*AW +: AW] != '0)
                    && (cnt_q[i_wb_waddr[p*AW +: AW]] != '0)
                    && (i_wb_tag[p*TAG_WIDTH +: TAG_WIDTH] == itag_q[i_wb_waddr[p*AW +: AW]]);
    end
  end

  always_comb begin
    for (int k = 0; k < RD_PORTS; k++) begin
      o_rd_ready[k] = (cnt_q[i_rd_addr[k*AW +: AW]] == '0);
    end
  end

  // Net counter change per register; an excess of writebacks clamps at zero and flags an error.
  always_comb begin
    err_d = 1'b0;
    net   = 0;
    for (int r = 0; r < REGS_TOTAL; r++) begin
      itag_d[r] = itag_q[r];
      cnt_d[r]  = cnt_q[r];
    end
    for (int r = 1; r < REGS_TOTAL; r++) begin
      net = int'(cnt_q[r]);
      if (issueAcc && (i_issue_waddr == AW'(r))) begin
        net       = net + 1;
        itag_d[r] = itag_q[r] + TAG_WIDTH'(1);
      end
      for (int p = 0; p < WB_PORTS; p++) begin
        if (i_wb_valid[p] && (i_wb_waddr[p*AW +: AW] == AW'(r))) begin
          net = net - 1;
        end
      end
      if (net < 0) begin
        err_d    = 1'b1;
        cnt_d[r] = '0;
      end else begin
        cnt_d[r] = TAG_WIDTH'(net);
      end
    end
    if (i_clear) begin
      err_d = 1'b0;
      for (int r = 0; r < REGS_TOTAL; r++) begin
        itag_d[r] = '0;
        cnt_d[r]  = '0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      err_q <= 1'b0;
      for (int r = 0; r < REGS_TOTAL; r++) begin
        itag_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
    end else begin
      err_q <= err_d;
      for (int r = 0; r < REGS_TOTAL; r++) begin
        itag_q[r] <= itag_d[r];
        cnt_q[r]  <= cnt_d[r];
      end
    end
  end

  assign o_err = err_q;

endmodule

// File: tb/tb_river_reg_scoreboard.sv
// Bench for river_reg_scoreboard: vector table plus hand sequences, with o_err
// expectations queued at drive time and checked after the following clock edge.
module tb_river_reg_scoreboard;

  logic        clk;
  logic        nrst;
  logic        clear;
  logic        issueValid;
  logic [5:0]  issueWaddr;
  logic        issueReady;
  logic [2:0]  issueTag;
  logic [1:0]  wbValid;
  logic [11:0] wbWaddr;
  logic [5:0]  wbTag;
  logic [1:0]  wbCommit;
  logic [17:0] rdAddr;
  logic [2:0]  rdReady;
  logic        err;

  int compared;
  int mismatched;
  bit errQueue [$];

  typedef struct {
    logic       iv;
    logic [5:0] ia;
    logic [1:0] wv;
    logic [5:0] wa0;
    logic [2:0] wt0;
    logic [5:0] wa1;
    logic [2:0] wt1;
    logic [5:0] r0;
    logic [5:0] r1;
    logic [5:0] r2;
    logic       clr;
    logic       eir;
    logic [2:0] eit;
    logic [1:0] ec;
    logic [2:0] erd;
    logic       eerr;
  } vec_t;

  vec_t tbl [15];

  river_reg_scoreboard dut (
    .i_clk         (clk),
    .i_nrst        (nrst),
    .i_clear       (clear),
    .i_issue_valid (issueValid),
    .i_issue_waddr (issueWaddr),
    .o_issue_ready (issueReady),
    .o_issue_tag   (issueTag),
    .i_wb_valid    (wbValid),
    .i_wb_waddr    (wbWaddr),
    .i_wb_tag      (wbTag),
    .o_wb_commit   (wbCommit),
    .i_rd_addr     (rdAddr),
    .o_rd_ready    (rdReady),
    .o_err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic iv, logic [5:0] ia, logic [1:0] wv,
                              logic [5:0] wa0, logic [2:0] wt0, logic [5:0] wa1, logic [2:0] wt1,
                              logic [5:0] r0, logic [5:0] r1, logic [5:0] r2, logic clr,
                              logic eir, logic [2:0] eit, logic [1:0] ec, logic [2:0] erd, logic eerr);
    vec_t v;
    v.iv = iv; v.ia = ia; v.wv = wv; v.wa0 = wa0; v.wt0 = wt0; v.wa1 = wa1; v.wt1 = wt1;
    v.r0 = r0; v.r1 = r1; v.r2 = r2; v.clr = clr;
    v.eir = eir; v.eit = eit; v.ec = ec; v.erd = erd; v.eerr = eerr;
    return v;
  endfunction

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Drive at negedge, check combinational outputs, then check o_err after the edge.
  task automatic applyStimulus(input vec_t v, input string nm);
    bit expErr;
    @(negedge clk);
    issueValid = v.iv;
    issueWaddr = v.ia;
    wbValid    = v.wv;
    wbWaddr    = {v.wa1, v.wa0};
    wbTag      = {v.wt1, v.wt0};
    rdAddr     = {v.r2, v.r1, v.r0};
    clear      = v.clr;
    #1;
    checkOutput({nm, ".issue_ready"}, 32'(issueReady), 32'(v.eir));
    checkOutput({nm, ".issue_tag"},   32'(issueTag),   32'(v.eit));
    checkOutput({nm, ".wb_commit"},   32'(wbCommit),   32'(v.ec));
    checkOutput({nm, ".rd_ready"},    32'(rdReady),    32'(v.erd));
    errQueue.push_back(v.eerr);
    @(posedge clk);
    #1;
    expErr = errQueue.pop_front();
    checkOutput({nm, ".err"}, 32'(err), 32'(expErr));
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    nrst = 1'b0; clear = 1'b0; issueValid = 1'b0; issueWaddr = '0;
    wbValid = '0; wbWaddr = '0; wbTag = '0; rdAddr = '0;

    //            iv ia  wv    wa0 wt0 wa1 wt1 r0 r1  r2 clr eir eit ec     erd     eerr
    tbl[0]  = mk(0, 0,  2'b00, 0,  0,  0,  0,  5, 10, 0, 0,  1,  0,  2'b00, 3'b111, 0);
    tbl[1]  = mk(1, 5,  2'b00, 0,  0,  0,  0,  5, 10, 0, 0,  1,  1,  2'b00, 3'b111, 0);
    tbl[2]  = mk(0, 5,  2'b00, 0,  0,  0,  0,  5, 10, 0, 0,  1,  2,  2'b00, 3'b110, 0);
    tbl[3]  = mk(1, 5,  2'b00, 0,  0,  0,  0,  5, 10, 0, 0,  1,  2,  2'b00, 3'b110, 0);
    tbl[4]  = mk(0, 5,  2'b01, 5,  1,  0,  0,  5, 10, 0, 0,  1,  3,  2'b00, 3'b110, 0);
    tbl[5]  = mk(0, 5,  2'b10, 0,  0,  5,  2,  5, 10, 0, 0,  1,  3,  2'b10, 3'b110, 0);
    tbl[6]  = mk(0, 5,  2'b00, 0,  0,  0,  0,  5, 10, 0, 0,  1,  3,  2'b00, 3'b111, 0);
    tbl[7]  = mk(0, 5,  2'b01, 3,  0,  0,  0,  5, 10, 3, 0,  1,  3,  2'b00, 3'b111, 1);
    tbl[8]  = mk(0, 5,  2'b10, 0,  0,  0,  0,  5, 10, 0, 0,  1,  3,  2'b00, 3'b111, 0);
    tbl[9]  = mk(1, 10, 2'b00, 0,  0,  0,  0,  5, 10, 0, 0,  1,  1,  2'b00, 3'b111, 0);
    tbl[10] = mk(1, 10, 2'b00, 0,  0,  0,  0,  5, 10, 0, 0,  1,  2,  2'b00, 3'b101, 0);
    tbl[11] = mk(1, 10, 2'b00, 0,  0,  0,  0,  5, 10, 0, 0,  1,  3,  2'b00, 3'b101, 0);
    tbl[12] = mk(1, 10, 2'b00, 0,  0,  0,  0,  5, 10, 0, 0,  1,  4,  2'b00, 3'b101, 0);
    tbl[13] = mk(1, 10, 2'b01, 10, 4,  0,  0,  5, 10, 0, 1,  1,  5,  2'b01, 3'b101, 0);
    tbl[14] = mk(0, 10, 2'b00, 0,  0,  0,  0,  5, 10, 0, 0,  1,  1,  2'b00, 3'b111, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    #1;
    checkOutput("reset.err", 32'(err), 32'd0);

    for (int i = 0; i < 15; i++) begin
      applyStimulus(tbl[i], $sformatf("vec%0d", i));
    end

    // x7 fills to the counter limit, stalls, drains one and wraps its tag.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(mk(1, 7, 2'b00, 0, 0, 0, 0, 7, 0, 0, 0, 1, 3'(i + 1), 2'b00,
                       (i == 0) ? 3'b111 : 3'b110, 0), $sformatf("x7_issue%0d", i));
    end
    applyStimulus(mk(1, 7, 2'b00, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0, 2'b00, 3'b110, 0), "x7_full");
    applyStimulus(mk(0, 7, 2'b00, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0, 2'b00, 3'b110, 0), "x7_hold");
    applyStimulus(mk(0, 7, 2'b01, 7, 7, 0, 0, 7, 0, 0, 0, 0, 0, 2'b01, 3'b110, 0), "x7_wb");
    applyStimulus(mk(1, 7, 2'b00, 0, 0, 0, 0, 7, 0, 0, 0, 1, 0, 2'b00, 3'b110, 0), "x7_wrap");
    applyStimulus(mk(0, 7, 2'b00, 0, 0, 0, 0, 7, 0, 0, 0, 0, 1, 2'b00, 3'b110, 0), "x7_after");

    // x9 reaches itag=0/cnt=1, then issue and writeback collide in one cycle.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(mk(1, 9, 2'b00, 0, 0, 0, 0, 9, 0, 0, 0, 1, 3'(i + 1), 2'b00,
                       (i == 0) ? 3'b111 : 3'b110, 0), $sformatf("x9_issue%0d", i));
    end
    for (int j = 1; j <= 7; j++) begin
      applyStimulus(mk(0, 9, 2'b01, 9, 3'(j), 0, 0, 9, 0, 0, 0, (j == 1) ? 1'b0 : 1'b1, 0,
                       (j == 7) ? 2'b01 : 2'b00, 3'b110, 0), $sformatf("x9_wb%0d", j));
    end
    applyStimulus(mk(1, 9, 2'b00, 0, 0, 0, 0, 9, 0, 0, 0, 1, 0, 2'b00, 3'b111, 0), "x9_wrapissue");
    applyStimulus(mk(1, 9, 2'b01, 9, 0, 0, 0, 9, 0, 0, 0, 1, 1, 2'b01, 3'b110, 0), "x9_collide");
    applyStimulus(mk(0, 9, 2'b01, 9, 1, 0, 0, 9, 0, 0, 0, 1, 2, 2'b01, 3'b110, 0), "x9_drain");
    applyStimulus(mk(0, 9, 2'b00, 0, 0, 0, 0, 9, 0, 0, 0, 1, 2, 2'b00, 3'b111, 0), "x9_ready");

    // Asynchronous reset while x7 still holds seven outstanding writes.
    @(negedge clk);
    issueValid = 1'b0; issueWaddr = 6'd7; clear = 1'b0;
    wbValid = 2'b01; wbWaddr = {6'd0, 6'd7}; wbTag = {3'd0, 3'd0};
    rdAddr = {6'd0, 6'd0, 6'd7};
    #1;
    checkOutput("prereset.wb_commit", 32'(wbCommit), 32'd1);
    checkOutput("prereset.issue_ready", 32'(issueReady), 32'd0);
    nrst = 1'b0;
    #1;
    checkOutput("midreset.issue_ready", 32'(issueReady), 32'd1);
    checkOutput("midreset.issue_tag", 32'(issueTag), 32'd1);
    checkOutput("midreset.wb_commit", 32'(wbCommit), 32'd0);
    checkOutput("midreset.rd_ready", 32'(rdReady), 32'd7);
    checkOutput("midreset.err", 32'(err), 32'd0);
    wbValid = 2'b00;
    @(negedge clk);
    nrst = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
